mips_cpu_load_store_unit: RTL and testbench
===========================================

MIPS_CPU_LOAD_STORE_UNIT -- requirements
Module: mips_cpu_load_store_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning the width of the CPU-side and memory-side address.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL change only on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The module SHALL have port req, input, 1, a CPU access request, sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 3, the access type: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
REQ-006 The module SHALL have port addr, input, ADDR_W, the byte address from the CPU.
REQ-007 The module SHALL have port wdata, input, 32, the store data, right-aligned for SB and SH.
REQ-008 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The module SHALL have port rdata, output, 32, the extended load result, valid while done is high.
REQ-011 The module SHALL have port misaligned, output, 1, a one-cycle error pulse in place of done.
REQ-012 The module SHALL have memory-side ports mem_address (output, ADDR_W), mem_read (output, 1), mem_write (output, 1), mem_writedata (output, 32) and mem_readdata (input, 32).
REQ-013 The memory SHALL be treated as byte-addressed and little-endian (byte at A+0 = bits 7:0), with combinational read and write committed on the clk edge.

Function
REQ-014 The state machine SHALL have states IDLE, READ, WRITE, DONE and ERR.
REQ-015 In IDLE, req=1 SHALL latch op, addr and wdata; the module SHALL NOT sample req again until it returns to IDLE.
REQ-016 Alignment rules: LW/SW SHALL require addr[1:0]=0; LH/LHU/SH SHALL require addr[0]=0; byte accesses are always aligned.
REQ-017 A misaligned request SHALL go IDLE->ERR->IDLE, pulse misaligned in ERR, and assert neither mem_read nor mem_write.
REQ-018 Loads SHALL follow IDLE->READ->DONE, with done exactly 2 cycles after the accepting edge.
REQ-019 SW SHALL follow IDLE->WRITE->DONE.
REQ-020 SB and SH SHALL follow IDLE->READ->WRITE->DONE as a read-modify-write.
REQ-021 mem_address SHALL equal {latched addr[ADDR_W-1:2],2'b00} in READ and WRITE, and 0 otherwise.
REQ-022 mem_read SHALL be high only in READ; mem_write SHALL be high only in WRITE; they SHALL never be high together.
REQ-023 In READ the module SHALL capture mem_readdata into an internal word register on the clk edge.
REQ-024 LB/LBU SHALL select byte addr[1:0]; LH/LHU SHALL select the half at addr[1]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-025 SB SHALL replace only byte addr[1:0] of the captured word with wdata[7:0]; SH SHALL replace only half addr[1] with wdata[15:0]; SW SHALL drive wdata directly.
REQ-026 rdata SHALL hold its last load value outside DONE, and SHALL be 0 after reset and after any store.
REQ-027 done and misaligned SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per request.
REQ-028 DONE and ERR SHALL return to IDLE unconditionally; back-to-back requests SHALL therefore be spaced by at least one IDLE cycle.

Reset
REQ-029 With reset=1 at a clk edge, the module SHALL enter IDLE and clear busy, done, misaligned, rdata, mem_read, mem_write, mem_address, mem_writedata and all latched registers.
REQ-030 Reset SHALL override any state, including mid-RMW; a reset in READ SHALL cause no write to be issued.
REQ-031 A req coincident with reset SHALL be dropped.

Structure
REQ-032 The op encodings and the state enumeration SHALL live in the shared package mips_cpu_pkg.
REQ-033 The byte/half extraction with extension, and the store merge, SHALL live in one combinational sub-module, mips_cpu_lsu_align.

Verification
REQ-034 Memory word at 0x10 preset to 0x8899AABB; LB at 0x11 -> done 2 cycles after accept, rdata=0xFFFFFFAA; LBU at 0x11 -> 0x000000AA.
REQ-035 Memory word at 0x10 = 0x8899AABB; LH at 0x12 -> rdata=0xFFFF8899; LW at 0x10 -> rdata=0x8899AABB.
REQ-036 Memory word at 0x20 = 0x11223344; SB at 0x22 with wdata=0x000000EE -> exactly one read and one write; memory word becomes 0x11EE3344.
REQ-037 SW at 0x21 -> misaligned pulse one cycle after accept, no mem_read or mem_write, done never high.
REQ-038 SH at 0x30 with reset asserted in the READ cycle -> no mem_write; module IDLE next cycle with all outputs 0.
REQ-039 req held high continuously with SW at 0x40 then LW at 0x40 -> second access accepted only after DONE->IDLE; loaded value equals the stored wdata.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS load/store unit.
//   lsu_op_e    : CPU access type encoding (LB..SW)
//   lsu_state_e : load/store unit control states
//   is_load / is_misaligned : decode helpers shared by the unit
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDone,
        StErr
    } lsu_state_e;

    function automatic logic is_load(lsu_op_e op);
        return (op == OpLb) || (op == OpLbu) || (op == OpLh) || (op == OpLhu) || (op == OpLw);
    endfunction

    function automatic logic is_misaligned(lsu_op_e op, logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OpLw, OpSw:        mis = (lo != 2'b00);
            OpLh, OpLhu, OpSh: mis = lo[0];
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational byte/half lane logic for the load/store unit.
// Ports:
//   op         : access type
//   byte_sel   : low two address bits of the access
//   load_word  : aligned word read from memory (load path)
//   old_word   : previously captured word (store merge path)
//   wdata      : right-aligned store data from the CPU
//   load_data  : extracted and sign/zero-extended load result
//   store_data : word to write back (merged for SB/SH, wdata for SW)
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Little-endian lanes: byte n lives in bits 8n+7:8n.
    assign sel_byte = load_word[{byte_sel, 3'b000} +: 8];
    assign sel_half = load_word[{byte_sel[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        case (op)
            OpLb:    load_data = {{24{sel_byte[7]}}, sel_byte};
            OpLbu:   load_data = {24'h0, sel_byte};
            OpLh:    load_data = {{16{sel_half[15]}}, sel_half};
            OpLhu:   load_data = {16'h0, sel_half};
            OpLw:    load_data = load_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_data = old_word;
        case (op)
            OpSb:    store_data[{byte_sel, 3'b000} +: 8]     = wdata[7:0];
            OpSh:    store_data[{byte_sel[1], 4'b0000} +: 16] = wdata[15:0];
            OpSw:    store_data = wdata;
            default: store_data = old_word;
        endcase
    end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// MIPS load/store unit: turns byte/half/word CPU accesses into aligned word
// accesses on a little-endian memory, using read-modify-write for SB/SH.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req, op, addr, wdata: CPU request (sampled only when idle)
//   busy, done, rdata   : status, completion pulse, load result
//   misaligned          : error pulse issued instead of done
//   mem_*               : word-aligned memory interface
module mips_cpu_load_store_unit
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic              accept;

    assign accept = (state_q == StIdle) && req;

    mips_cpu_lsu_align u_align (
        .op         (op_q),
        .byte_sel   (addr_q[1:0]),
        .load_word  (mem_readdata),
        .old_word   (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpLb;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= lsu_op_e'(op);
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == StRead) begin
                word_q <= mem_readdata;
                if (is_load(op_q)) begin
                    rdata_q <= load_data;
                end
            end
            // Stores leave no load result behind.
            if (state_q == StWrite) begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (is_misaligned(lsu_op_e'(op), addr[1:0])) begin
                        state_d = StErr;
                    end else if (lsu_op_e'(op) == OpSw) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = is_load(op_q) ? StDone : StWrite;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        misaligned    = (state_q == StErr);
        mem_read      = (state_q == StRead);
        mem_write     = (state_q == StWrite);
        rdata         = rdata_q;
        mem_address   = '0;
        mem_writedata = '0;
        if (mem_read || mem_write) begin
            mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        end
        if (mem_write) begin
            mem_writedata = store_data;
        end
    end

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
module tb_mips_cpu_load_store_unit;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misaligned, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_writedata, mem_readdata;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int tests = 0;
    int fails = 0;
    int wr_total = 0;

    // Per-access observations
    int          lat, n_rd, n_wr, n_done, n_mis;
    logic        both_seen;
    logic [31:0] got_rdata;

    always #5 clk = ~clk;

    mips_cpu_load_store_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .op            (op),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .misaligned    (misaligned),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    assign mem_readdata = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[7:2]] <= mem_writedata;
            wr_total <= wr_total + 1;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One request, then watch 6 cycles; lat = cycles after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; n_rd = 0; n_wr = 0; n_done = 0; n_mis = 0; both_seen = 1'b0;
        got_rdata = 'x;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if (mem_read && mem_write) both_seen = 1'b1;
            if (done) begin
                n_done++;
                got_rdata = rdata;
                if (lat == 0) lat = c;
            end
            if (misaligned) begin
                n_mis++;
                if (lat == 0) lat = c;
            end
        end
    endtask

    initial begin
        // Reset with a coincident request that must be dropped.
        req = 1'b1; op = OpLw; addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_mem_addr", mem_address, 0);
        chk("reset_mem_rw", {mem_read, mem_write}, 0);
        @(negedge clk);
        chk("reset_req_dropped", busy, 0);

        preload(6'h04, 32'h8899AABB);
        preload(6'h08, 32'h11223344);
        preload(6'h0C, 32'h55667788);
        preload(6'h10, 32'h00000000);

        issue(OpLb, 32'h11, 0);
        chk("lb_latency", lat, 2);
        chk("lb_rdata", got_rdata, 32'hFFFFFFAA);
        chk("lb_one_read", n_rd, 1);
        chk("lb_no_write", n_wr, 0);

        issue(OpLbu, 32'h11, 0);
        chk("lbu_rdata", got_rdata, 32'h000000AA);

        issue(OpLh, 32'h12, 0);
        chk("lh_rdata", got_rdata, 32'hFFFF8899);

        issue(OpLhu, 32'h10, 0);
        chk("lhu_rdata", got_rdata, 32'h0000AABB);

        issue(OpLw, 32'h10, 0);
        chk("lw_rdata", got_rdata, 32'h8899AABB);
        chk("lw_done_once", n_done, 1);
        chk("lw_rdata_hold", rdata, 32'h8899AABB);

        issue(OpSb, 32'h22, 32'h000000EE);
        chk("sb_latency", lat, 3);
        chk("sb_reads", n_rd, 1);
        chk("sb_writes", n_wr, 1);
        chk("sb_rw_exclusive", both_seen, 0);
        chk("sb_mem", mem[8], 32'h11EE3344);
        chk("sb_rdata_zero", got_rdata, 0);

        issue(OpSh, 32'h22, 32'h0000BEEF);
        chk("sh_mem", mem[8], 32'hBEEF3344);

        issue(OpSw, 32'h21, 32'hDEADBEEF);
        chk("sw_mis_latency", lat, 1);
        chk("sw_mis_pulses", n_mis, 1);
        chk("sw_mis_no_done", n_done, 0);
        chk("sw_mis_no_mem", n_rd + n_wr, 0);
        chk("sw_mis_mem", mem[8], 32'hBEEF3344);

        issue(OpLh, 32'h11, 0);
        chk("lh_mis_pulses", n_mis, 1);
        chk("lh_mis_no_read", n_rd, 0);

        // Reset during the READ phase of an SH read-modify-write.
        @(negedge clk);
        req = 1'b1; op = OpSh; addr = 32'h30; wdata = 32'h00001234;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_read", mem_read, 1);
        chk("rst_mid_addr", mem_address, 32'h30);
        begin
            int wr_before;
            wr_before = wr_total;
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_flags", {done, misaligned, mem_read, mem_write}, 0);
            chk("rst_mid_rdata", rdata, 0);
            chk("rst_mid_mem_addr", mem_address, 0);
            chk("rst_mid_wdata", mem_writedata, 0);
            repeat (3) @(negedge clk);
            chk("rst_mid_no_write", wr_total - wr_before, 0);
            chk("rst_mid_mem", mem[12], 32'h55667788);
        end

        // req held high: SW then LW to the same address.
        @(negedge clk);
        req = 1'b1; op = OpSw; addr = 32'h40; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_sw_write", mem_write, 1);
        chk("b2b_sw_no_read", mem_read, 0);
        @(negedge clk);
        chk("b2b_sw_done", done, 1);
        chk("b2b_sw_rdata", rdata, 0);
        op = OpLw; wdata = 32'h0;
        @(negedge clk);
        chk("b2b_idle_gap", busy, 0);
        @(negedge clk);
        chk("b2b_lw_read", mem_read, 1);
        req = 1'b0;
        @(negedge clk);
        chk("b2b_lw_done", done, 1);
        chk("b2b_lw_rdata", rdata, 32'hCAFEF00D);
        @(negedge clk);
        chk("b2b_end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
